// File: rtl/cia_bus_pkg.sv
// Shared types and defaults for the CIA register bus controller.
// Holds the FSM state encoding and default hold/timeout constants.
package cia_bus_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WAIT_E_RISE  = 3'd1,
      ACCESS       = 3'd2,
      READ_HOLD    = 3'd3,
      WAIT_RELEASE = 3'd4
   } cia_state_e;

   localparam int CIA_HOLD_CYCLES = 4;
   localparam int CIA_TIMEOUT     = 255;

endpackage

// File: rtl/cia_e_edge.sv
// E clock edge detector: compares e with its registered previous value.
// Ports: clk, rst_n (async low), e in; rise, fall out (one clk each).
module cia_e_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic e,
   output logic rise,
   output logic fall
);

   logic e_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q <= 1'b0;
      end else begin
         e_q <= e;
      end
   end

   // Edges are acted on at the first clk that samples the new e level.
   assign rise = e & ~e_q;
   assign fall = ~e & e_q;

endmodule

// File: rtl/cia_bus_ctrl.sv
// CIA-style bus cycle controller bridging E-clocked bus to a register file.
// Ports: clk, _reset, bus strobes/data in; register strobes, bus drive out.
module cia_bus_ctrl
   import cia_bus_pkg::*;
#(
   parameter int HOLD_CYCLES = CIA_HOLD_CYCLES,
   parameter int TIMEOUT     = CIA_TIMEOUT
) (
   input  logic       clk,
   input  logic       _reset,
   input  logic       reg_decode,
   input  logic       r_w,
   input  logic       _cs,
   input  logic       e,
   input  logic [3:0] reg_addr,
   input  logic [7:0] data_in,
   input  logic [7:0] rd_data,
   output logic       wr_strobe,
   output logic       rd_req,
   output logic [3:0] addr,
   output logic [7:0] wr_data,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       abort
);

   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam int HC_W = $clog2(HOLD_CYCLES + 1);

   cia_state_e      state_q, state_d;
   logic            rw_q, rw_d;
   logic [3:0]      addr_q, addr_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic [7:0]      data_out_q, data_out_d;
   logic            wr_pend_q, wr_pend_d;
   logic            wr_strobe_q, wr_strobe_d;
   logic            rd_req_q, rd_req_d;
   logic            data_oe_q, data_oe_d;
   logic            abort_q, abort_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [HC_W-1:0] hold_q, hold_d;
   logic            e_rise, e_fall, timeout;

   cia_e_edge u_edge (
      .clk   (clk),
      .rst_n (_reset),
      .e     (e),
      .rise  (e_rise),
      .fall  (e_fall)
   );

   assign timeout = (state_q != IDLE)
                 && (to_cnt_q == TO_W'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wr_data_d   = wr_data_q;
      data_out_d  = data_out_q;
      wr_pend_d   = 1'b0;
      // Write strobe trails the data latch by one clk.
      wr_strobe_d = wr_pend_q;
      rd_req_d    = 1'b0;
      data_oe_d   = data_oe_q;
      abort_d     = 1'b0;
      hold_d      = hold_q;
      to_cnt_d    = (state_q == IDLE) ? '0 : to_cnt_q + 1'b1;

      // Register file answers the cycle after rd_req.
      if (rd_req_q) begin
         data_out_d = rd_data;
         data_oe_d  = 1'b1;
      end

      if (timeout) begin
         state_d   = IDLE;
         abort_d   = 1'b1;
         data_oe_d = 1'b0;
         to_cnt_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!_cs && reg_decode) begin
                  state_d = WAIT_E_RISE;
                  addr_d  = reg_addr;
                  rw_d    = r_w;
               end
            end
            WAIT_E_RISE: begin
               if (_cs) begin
                  state_d   = IDLE;
                  abort_d   = 1'b1;
                  data_oe_d = 1'b0;
               end else if (e_rise) begin
                  state_d  = ACCESS;
                  rd_req_d = rw_q;
               end
            end
            ACCESS: begin
               if (_cs) begin
                  state_d   = IDLE;
                  abort_d   = 1'b1;
                  data_oe_d = 1'b0;
               end else if (e_fall) begin
                  if (rw_q) begin
                     state_d = READ_HOLD;
                     hold_d  = '0;
                  end else begin
                     state_d   = WAIT_RELEASE;
                     wr_data_d = data_in;
                     wr_pend_d = 1'b1;
                  end
               end
            end
            READ_HOLD: begin
               // _cs release here is a normal end; the hold still runs out.
               if (hold_q == HC_W'(HOLD_CYCLES - 1)) begin
                  state_d   = WAIT_RELEASE;
                  data_oe_d = 1'b0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            WAIT_RELEASE: begin
               if (_cs) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_q     <= IDLE;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         data_out_q  <= '0;
         wr_pend_q   <= 1'b0;
         wr_strobe_q <= 1'b0;
         rd_req_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         abort_q     <= 1'b0;
         to_cnt_q    <= '0;
         hold_q      <= '0;
      end else begin
         state_q     <= state_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wr_data_q   <= wr_data_d;
         data_out_q  <= data_out_d;
         wr_pend_q   <= wr_pend_d;
         wr_strobe_q <= wr_strobe_d;
         rd_req_q    <= rd_req_d;
         data_oe_q   <= data_oe_d;
         abort_q     <= abort_d;
         to_cnt_q    <= to_cnt_d;
         hold_q      <= hold_d;
      end
   end

   assign wr_strobe = wr_strobe_q;
   assign rd_req    = rd_req_q;
   assign addr      = addr_q;
   assign wr_data   = wr_data_q;
   assign data_out  = data_out_q;
   assign data_oe   = data_oe_q;
   assign abort     = abort_q;

endmodule

// File: tb/tb_cia_bus_ctrl.sv
// Self-checking bench for cia_bus_ctrl.
// Scoreboard queues hold expected writes/read data per bus cycle.
module tb_cia_bus_ctrl;

   localparam int HOLD = 4;
   localparam int TOUT = 255;

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   logic       clk;
   logic       _reset;
   logic       reg_decode;
   logic       r_w;
   logic       _cs;
   logic       e;
   logic [3:0] reg_addr;
   logic [7:0] data_in;
   logic [7:0] rd_data;
   logic       wr_strobe;
   logic       rd_req;
   logic [3:0] addr;
   logic [7:0] wr_data;
   logic [7:0] data_out;
   logic       data_oe;
   logic       abort;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int ab_cnt = 0;
   int both_cnt = 0;

   wr_t        wr_exp[$];
   logic [7:0] rd_exp[$];

   cia_bus_ctrl #(
      .HOLD_CYCLES (HOLD),
      .TIMEOUT     (TOUT)
   ) dut (
      .clk        (clk),
      ._reset     (_reset),
      .reg_decode (reg_decode),
      .r_w        (r_w),
      ._cs        (_cs),
      .e          (e),
      .reg_addr   (reg_addr),
      .data_in    (data_in),
      .rd_data    (rd_data),
      .wr_strobe  (wr_strobe),
      .rd_req     (rd_req),
      .addr       (addr),
      .wr_data    (wr_data),
      .data_out   (data_out),
      .data_oe    (data_oe),
      .abort      (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe) wr_cnt++;
      if (rd_req) rd_cnt++;
      if (abort) ab_cnt++;
      if (wr_strobe && rd_req) both_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d,
                           output int lat, output logic [3:0] sa,
                           output logic [7:0] sd);
      _cs = 1'b0; reg_decode = 1'b1; reg_addr = a; r_w = 1'b0;
      data_in = 8'h00;
      tick();
      reg_decode = 1'b0; reg_addr = ~a; r_w = 1'b1;
      e = 1'b1;
      tick();
      tick();
      data_in = d; e = 1'b0;
      lat = -1; sa = '0; sd = '0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (wr_strobe) begin
            lat = i; sa = addr; sd = wr_data;
            break;
         end
      end
   endtask

   task automatic test_reset();
      _reset = 1'b0; _cs = 1'b1; reg_decode = 1'b0; r_w = 1'b0;
      e = 1'b0; reg_addr = '0; data_in = '0; rd_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (wr_strobe !== 1'b0) begin errors++;
         $display("FAIL rst_wr_strobe got %b want 0", wr_strobe); end
      checks++; if (rd_req !== 1'b0) begin errors++;
         $display("FAIL rst_rd_req got %b want 0", rd_req); end
      checks++; if (abort !== 1'b0) begin errors++;
         $display("FAIL rst_abort got %b want 0", abort); end
      checks++; if (data_oe !== 1'b0) begin errors++;
         $display("FAIL rst_data_oe got %b want 0", data_oe); end
      checks++; if (addr !== 4'h0) begin errors++;
         $display("FAIL rst_addr got %h want 0", addr); end
      checks++; if (wr_data !== 8'h00) begin errors++;
         $display("FAIL rst_wr_data got %h want 00", wr_data); end
      checks++; if (data_out !== 8'h00) begin errors++;
         $display("FAIL rst_data_out got %h want 00", data_out); end
      _reset = 1'b1;
      tick();
      tick();
      checks++; if (abort !== 1'b0 || data_oe !== 1'b0) begin errors++;
         $display("FAIL post_rst_idle abort=%b oe=%b want 0 0",
                  abort, data_oe); end
   endtask

   task automatic test_write();
      int lat; logic [3:0] sa; logic [7:0] sd; wr_t ex;
      int rd0;
      rd0 = rd_cnt;
      wr_exp.push_back('{a: 4'h3, d: 8'hA5});
      do_write(4'h3, 8'hA5, lat, sa, sd);
      checks++; if (lat !== 2) begin errors++;
         $display("FAIL wr_latency got %0d want 2", lat); end
      if (wr_exp.size() == 0) begin
         errors++; $display("FAIL wr_scoreboard empty");
      end else begin
         ex = wr_exp.pop_front();
         checks++; if (sa !== ex.a) begin errors++;
            $display("FAIL wr_addr got %h want %h", sa, ex.a); end
         checks++; if (sd !== ex.d) begin errors++;
            $display("FAIL wr_data got %h want %h", sd, ex.d); end
      end
      tick();
      checks++; if (wr_strobe !== 1'b0) begin errors++;
         $display("FAIL wr_pulse_width got %b want 0", wr_strobe); end
      _cs = 1'b1;
      tick();
      checks++; if (rd_cnt != rd0) begin errors++;
         $display("FAIL wr_no_rd_req got %0d want %0d", rd_cnt, rd0); end
   endtask

   task automatic test_read(input logic [3:0] a, input logic [7:0] d,
                            input bit rel_in_hold);
      int ab0; int rd0; int held; logic [7:0] ex;
      ab0 = ab_cnt; rd0 = rd_cnt;
      rd_data = d; rd_exp.push_back(d);
      _cs = 1'b0; reg_decode = 1'b1; reg_addr = a; r_w = 1'b1;
      tick();
      reg_decode = 1'b0; reg_addr = ~a; r_w = 1'b0;
      e = 1'b1;
      tick();
      checks++; if (rd_req !== 1'b1 || data_oe !== 1'b0) begin errors++;
         $display("FAIL rd_req_timing rd_req=%b oe=%b want 1 0",
                  rd_req, data_oe); end
      tick();
      checks++; if (rd_req !== 1'b0 || data_oe !== 1'b1) begin errors++;
         $display("FAIL rd_oe_timing rd_req=%b oe=%b want 0 1",
                  rd_req, data_oe); end
      if (rd_exp.size() == 0) begin
         errors++; $display("FAIL rd_scoreboard empty");
      end else begin
         ex = rd_exp.pop_front();
         checks++; if (data_out !== ex) begin errors++;
            $display("FAIL rd_data_out got %h want %h", data_out, ex); end
      end
      checks++; if (addr !== a) begin errors++;
         $display("FAIL rd_addr got %h want %h", addr, a); end
      tick();
      e = 1'b0;
      held = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!data_oe) break;
         held++;
         if (rel_in_hold && i == 0) _cs = 1'b1;
      end
      checks++; if (held != HOLD) begin errors++;
         $display("FAIL rd_hold got %0d want %0d", held, HOLD); end
      _cs = 1'b1;
      tick();
      tick();
      checks++; if (ab_cnt != ab0) begin errors++;
         $display("FAIL rd_no_abort got %0d want %0d", ab_cnt, ab0); end
      checks++; if (rd_cnt != rd0 + 1) begin errors++;
         $display("FAIL rd_req_count got %0d want %0d", rd_cnt, rd0 + 1); end
   endtask

   task automatic test_early_release();
      int ab0; int wr0;
      ab0 = ab_cnt; wr0 = wr_cnt;
      _cs = 1'b0; reg_decode = 1'b1; reg_addr = 4'h3; r_w = 1'b0;
      tick();
      reg_decode = 1'b0;
      e = 1'b1;
      tick();
      tick();
      _cs = 1'b1;
      tick();
      checks++; if (abort !== 1'b1 || wr_strobe !== 1'b0) begin errors++;
         $display("FAIL early_abort abort=%b wr=%b want 1 0",
                  abort, wr_strobe); end
      data_in = 8'h77; e = 1'b0;
      tick();
      checks++; if (abort !== 1'b0) begin errors++;
         $display("FAIL early_abort_width got %b want 0", abort); end
      repeat (4) tick();
      checks++; if (wr_cnt != wr0 || ab_cnt != ab0 + 1) begin errors++;
         $display("FAIL early_counts wr=%0d ab=%0d want %0d %0d",
                  wr_cnt, ab_cnt, wr0, ab0 + 1); end
   endtask

   task automatic test_timeout();
      int got;
      _cs = 1'b0; reg_decode = 1'b1; reg_addr = 4'h5; r_w = 1'b1;
      e = 1'b0;
      tick();
      reg_decode = 1'b0;
      got = -1;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (abort) begin
            got = i;
            break;
         end
      end
      checks++; if (got != TOUT) begin errors++;
         $display("FAIL timeout_cycle got %0d want %0d", got, TOUT); end
      checks++; if (data_oe !== 1'b0) begin errors++;
         $display("FAIL timeout_oe got %b want 0", data_oe); end
      _cs = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_read();
      int lat; int wr0; logic [3:0] sa; logic [7:0] sd; wr_t ex;
      logic [7:0] rex;
      rd_data = 8'hC3; rd_exp.push_back(8'hC3);
      _cs = 1'b0; reg_decode = 1'b1; reg_addr = 4'h9; r_w = 1'b1;
      tick();
      reg_decode = 1'b0;
      e = 1'b1;
      tick();
      tick();
      rex = rd_exp.pop_front();
      checks++; if (data_out !== rex) begin errors++;
         $display("FAIL rst_mid_data got %h want %h", data_out, rex); end
      e = 1'b0;
      tick();
      tick();
      checks++; if (data_oe !== 1'b1) begin errors++;
         $display("FAIL rst_mid_pre_oe got %b want 1", data_oe); end
      wr0 = wr_cnt;
      #2;
      _reset = 1'b0;
      #1;
      checks++; if (data_oe !== 1'b0 || wr_strobe !== 1'b0) begin errors++;
         $display("FAIL rst_mid_async oe=%b wr=%b want 0 0",
                  data_oe, wr_strobe); end
      tick();
      tick();
      _reset = 1'b1; _cs = 1'b1;
      tick();
      wr_exp.push_back('{a: 4'h7, d: 8'h3C});
      do_write(4'h7, 8'h3C, lat, sa, sd);
      ex = wr_exp.pop_front();
      checks++; if (lat !== 2 || sa !== ex.a || sd !== ex.d) begin
         errors++;
         $display("FAIL rst_mid_write lat=%0d a=%h d=%h want 2 %h %h",
                  lat, sa, sd, ex.a, ex.d); end
      _cs = 1'b1;
      tick();
      tick();
      checks++; if (wr_cnt != wr0 + 1) begin errors++;
         $display("FAIL rst_mid_wr_count got %0d want %0d",
                  wr_cnt, wr0 + 1); end
   endtask

   task automatic test_back_to_back();
      int lat1; int lat2; int wr0;
      logic [3:0] sa1; logic [3:0] sa2;
      logic [7:0] sd1; logic [7:0] sd2;
      wr_t ex;
      wr0 = wr_cnt;
      wr_exp.push_back('{a: 4'h1, d: 8'h11});
      wr_exp.push_back('{a: 4'hE, d: 8'hE2});
      do_write(4'h1, 8'h11, lat1, sa1, sd1);
      _cs = 1'b1;
      tick();
      do_write(4'hE, 8'hE2, lat2, sa2, sd2);
      _cs = 1'b1;
      tick();
      tick();
      ex = wr_exp.pop_front();
      checks++; if (lat1 !== 2 || sa1 !== ex.a || sd1 !== ex.d) begin
         errors++;
         $display("FAIL b2b_first lat=%0d a=%h d=%h want 2 %h %h",
                  lat1, sa1, sd1, ex.a, ex.d); end
      ex = wr_exp.pop_front();
      checks++; if (lat2 !== 2 || sa2 !== ex.a || sd2 !== ex.d) begin
         errors++;
         $display("FAIL b2b_second lat=%0d a=%h d=%h want 2 %h %h",
                  lat2, sa2, sd2, ex.a, ex.d); end
      checks++; if (wr_cnt != wr0 + 2) begin errors++;
         $display("FAIL b2b_count got %0d want %0d", wr_cnt, wr0 + 2); end
      checks++; if (both_cnt != 0) begin errors++;
         $display("FAIL wr_rd_overlap got %0d want 0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read(4'hD, 8'h5C, 1'b0);
      test_read(4'h6, 8'h96, 1'b1);
      test_early_release();
      test_timeout();
      test_reset_mid_read();
      test_back_to_back();
      checks++; if (wr_exp.size() != 0 || rd_exp.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left wr=%0d rd=%0d want 0 0",
                  wr_exp.size(), rd_exp.size()); end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
